imem_access_ctrl: RTL
=====================

// Module: imem_access_ctrl
// PURPOSE
//  Sequencer/arbiter for the byte-wide single-port instruction memory (4096 x 8, async read).
//  Shares the array between the core's fetch port and the network program loader.
//  Each word access = 4 byte beats, little-endian: byte at A+0 -> bits [7:0] ... A+3 -> [31:24].
//  Sits between fetch stage / loader and the byte array; owns all array address/write strobes.
// PARAMETERS
//  ADDR_W   12   byte-address width of the array (depth 2**ADDR_W bytes)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  fetch_req    in   1       fetch request; held high with fetch_addr stable until fetch_valid
//  fetch_addr   in   32      fetch byte address; [1:0] ignored, bits >= ADDR_W ignored
//  fetch_valid  out  1       one-cycle ack; fetch_data valid this cycle
//  fetch_data   out  32      assembled instruction word; holds until next fetch completes
//  load_req     in   1       loader write request; held with load_addr/load_data until load_ack
//  load_addr    in   32      write byte address; same alignment/truncation as fetch_addr
//  load_data    in   32      word to write, little-endian byte order
//  load_ack     out  1       one-cycle ack; all 4 bytes written
//  mem_addr     out  ADDR_W  array byte address
//  mem_we       out  1       array byte write enable
//  mem_wdata    out  8       array write byte
//  mem_rdata    in   8       array read byte, combinational from mem_addr
//  busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE, beat=0, last_grant=LOAD; all outputs 0; latched addr/data cleared.
//    Reset mid-transaction aborts it: no ack, no further writes, next cycle mem_we=0.
//  - FSM: IDLE -> READ|WRITE -> DONE -> IDLE. 2-bit beat counter counts 0..3 in READ/WRITE.
//  - IDLE (cycle T): sample requests; if granted, latch {addr[ADDR_W-1:2]} (+load_data), beat=0.
//  - Arbitration in IDLE: only one req -> grant it. Both -> grant side not in last_grant
//    (round-robin); after reset fetch wins first tie. last_grant updated on grant. No preemption.
//  - READ (T+1..T+4): mem_addr={addr_q,beat}, mem_we=0; byte lane[beat] <= mem_rdata each cycle.
//  - WRITE (T+1..T+4): mem_addr={addr_q,beat}, mem_we=1, mem_wdata=data_q[8*beat+:8].
//  - Beat 3 -> DONE. DONE (T+5): fetch_valid=1 (with fetch_data) or load_ack=1, exactly one cycle.
//    DONE -> IDLE at T+6; requester drops req in the cycle after ack, so req is not re-granted.
//  - Latency request-to-ack 5 cycles; throughput one word per 6 cycles.
//  - Outside READ/WRITE: mem_addr=0, mem_we=0, mem_wdata=0.
//  - Address wrap: only bits [ADDR_W-1:2] used; beat addition never carries out of word.
//  - Req deasserted mid-transaction: transaction still completes and acks (requester violation,
//    behaviour defined but not relied upon).
//  - fetch_data updates only on fetch completion; a load never alters fetch_data.
// STRUCTURE
//  - imem_ctrl_pkg: state enum {IDLE, READ, WRITE, DONE}; GRANT_FETCH=1'b0, GRANT_LOAD=1'b1;
//    BEATS_PER_WORD=4.
//  - Single module; no sub-module. Bench supplies imem_byte_model (4096x8 array, async read,
//    sync write) driven by mem_* ports.
// TESTING
//  1. Assert reset 3 cycles -> all outputs 0, busy=0, mem_we never high.
//  2. load 0x11223344 @0x010 -> writes 0x010=44, 0x011=33, 0x012=22, 0x013=11 in T+1..T+4;
//     load_ack=1 only at T+5.
//  3. fetch @0x013 after test 2 -> mem_addr 0x010..0x013, fetch_valid at T+5,
//     fetch_data=0x11223344.
//  4. Both req in same cycle after reset -> fetch served first, then load; repeat tie -> fetch
//     again (last_grant=LOAD); order fetch,load,fetch with 6-cycle spacing.
//  5. reset during READ beat 2 -> no fetch_valid, next cycle busy=0, mem_addr=0; subsequent
//     fetch @0x010 returns 0x11223344.
//  6. fetch @0x0000_1004 with bytes 0x004..0x007 = AA,BB,CC,DD -> fetch_data=0xDDCCBBAA.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// Word accesses are four little-endian byte beats on a byte-wide array.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_LOAD  = 1'b1;

    localparam int unsigned BEATS_PER_WORD = 4;
    localparam int unsigned BEAT_W         = 2;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;

    // Little-endian byte lane select: lane 0 is bits [7:0].
    function automatic logic [BYTE_W-1:0] byte_lane(input logic [WORD_W-1:0] word,
                                                    input logic [BEAT_W-1:0] lane);
        return word[{lane, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/imem_access_ctrl.sv
// Arbitrates fetch and loader access to a byte-wide instruction array and
// sequences each word access as four byte beats (read assembles, write scatters).
module imem_access_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    input  logic              load_req,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam int unsigned WADDR_W = ADDR_W - 2;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [BEAT_W-1:0]    r_beat;
    logic [BEAT_W-1:0]    w_beat_nxt;
    logic                 r_last_grant;
    logic                 w_last_nxt;
    logic [WADDR_W-1:0]   r_addr;
    logic [WADDR_W-1:0]   w_addr_nxt;
    logic [WORD_W-1:0]    r_data;
    logic [WORD_W-1:0]    w_data_nxt;
    logic [23:0]          r_rbuf;

    logic                 r_fetch_valid;
    logic                 w_fetch_valid_nxt;
    logic [WORD_W-1:0]    r_fetch_data;
    logic                 r_load_ack;
    logic                 w_load_ack_nxt;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [ADDR_W-1:0]    w_mem_addr_nxt;
    logic                 r_mem_we;
    logic                 w_mem_we_nxt;
    logic [BYTE_W-1:0]    r_mem_wdata;
    logic [BYTE_W-1:0]    w_mem_wdata_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;

    logic                 w_grant_fetch;
    logic                 w_grant_load;
    logic                 w_last_beat;
    logic                 w_unused_addr_bits;

    // Round-robin on a tie: the side that did not win last time goes first.
    assign w_grant_fetch = fetch_req & (~load_req | (r_last_grant == GRANT_LOAD));
    assign w_grant_load  = load_req & ~w_grant_fetch;
    assign w_last_beat   = (r_beat == BEAT_W'(BEATS_PER_WORD - 1));

    assign w_unused_addr_bits = ^{fetch_addr[31:ADDR_W], fetch_addr[1:0],
                                  load_addr[31:ADDR_W], load_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_beat_nxt        = r_beat;
        w_last_nxt        = r_last_grant;
        w_addr_nxt        = r_addr;
        w_data_nxt        = r_data;
        w_fetch_valid_nxt = 1'b0;
        w_load_ack_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_beat_nxt = '0;
                if (w_grant_fetch) begin
                    w_state_nxt = READ;
                    w_addr_nxt  = fetch_addr[ADDR_W-1:2];
                    w_last_nxt  = GRANT_FETCH;
                end else if (w_grant_load) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = load_addr[ADDR_W-1:2];
                    w_data_nxt  = load_data;
                    w_last_nxt  = GRANT_LOAD;
                end
            end
            READ, WRITE: begin
                w_beat_nxt = r_beat + 2'd1;
                if (w_last_beat) begin
                    w_state_nxt       = DONE;
                    w_fetch_valid_nxt = (r_state == READ);
                    w_load_ack_nxt    = (r_state == WRITE);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Array strobes are registered from the next-state view so they line up with each beat.
    always_comb begin
        w_mem_addr_nxt  = '0;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = '0;
        if ((w_state_nxt == READ) || (w_state_nxt == WRITE)) begin
            w_mem_addr_nxt = {w_addr_nxt, w_beat_nxt};
        end
        if (w_state_nxt == WRITE) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = byte_lane(w_data_nxt, w_beat_nxt);
        end
    end

    assign w_busy_nxt = (w_state_nxt != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat        <= '0;
            r_last_grant  <= GRANT_LOAD;
            r_addr        <= '0;
            r_data        <= '0;
            r_fetch_valid <= 1'b0;
            r_load_ack    <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_beat        <= w_beat_nxt;
            r_last_grant  <= w_last_nxt;
            r_addr        <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_load_ack    <= w_load_ack_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Read lanes collect per beat; the fetched word only changes when beat 3 lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rbuf       <= '0;
            r_fetch_data <= '0;
        end else if (r_state == READ) begin
            unique case (r_beat)
                2'd0: r_rbuf[7:0]   <= mem_rdata;
                2'd1: r_rbuf[15:8]  <= mem_rdata;
                2'd2: r_rbuf[23:16] <= mem_rdata;
                2'd3: r_fetch_data  <= {mem_rdata, r_rbuf};
                default: r_rbuf     <= r_rbuf;
            endcase
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_data  = r_fetch_data;
    assign load_ack    = r_load_ack;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;

endmodule
